// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input mapper.
//   dir_e          : direction bit positions inside a 4-bit {up,down,left,right} group
//   rot_e          : screen rotation codes carried on the rotate input
//   key_fn_e       : role a keyboard scancode plays for a player
//   KEYMAP         : fixed table of {player, role, 9-bit code}
//   JOY_*          : MiSTer joystick word bit positions
//   rotate_dirs    : remaps physical directions for a rotated screen
//   socd_clean     : neutralises opposing directions on each axis
//   key_btn_index  : button number for a button role, -1 otherwise
package arcade_input_pkg;

  // Values equal the bit index inside a direction group, which is also the
  // MiSTer joystick bit layout ([3] up .. [0] right).
  typedef enum logic [1:0] {
    UP    = 2'd3,
    DOWN  = 2'd2,
    LEFT  = 2'd1,
    RIGHT = 2'd0
  } dir_e;

  typedef enum logic [1:0] {
    ROT0    = 2'd0,
    ROT_CW  = 2'd1,
    ROT_CCW = 2'd2,
    ROT180  = 2'd3
  } rot_e;

  typedef enum logic [3:0] {
    K_UP,
    K_DOWN,
    K_LEFT,
    K_RIGHT,
    K_BTN0,
    K_BTN1,
    K_BTN2,
    K_START,
    K_COIN,
    K_TEST,
    K_SERVICE
  } key_fn_e;

  typedef struct packed {
    logic [1:0] player;
    key_fn_e    fn;
    logic [8:0] code;   // {extended, scancode}
  } keymap_entry_t;

  localparam int JOY_WORD  = 16;
  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_BTN0  = 4;

  localparam int NKEYS = 26;

  // Test and service are global switches; they sit on player 0 in the table.
  localparam keymap_entry_t KEYMAP [NKEYS] = '{
    '{2'd0, K_UP,      9'h175},
    '{2'd0, K_DOWN,    9'h172},
    '{2'd0, K_LEFT,    9'h16B},
    '{2'd0, K_RIGHT,   9'h174},
    '{2'd0, K_BTN0,    9'h014},
    '{2'd0, K_BTN1,    9'h011},
    '{2'd0, K_BTN2,    9'h029},
    '{2'd1, K_UP,      9'h02D},
    '{2'd1, K_DOWN,    9'h02B},
    '{2'd1, K_LEFT,    9'h023},
    '{2'd1, K_RIGHT,   9'h034},
    '{2'd1, K_BTN0,    9'h01C},
    '{2'd1, K_BTN1,    9'h01B},
    '{2'd1, K_BTN2,    9'h015},
    '{2'd0, K_START,   9'h016},
    '{2'd1, K_START,   9'h01E},
    '{2'd2, K_START,   9'h026},
    '{2'd3, K_START,   9'h025},
    '{2'd0, K_START,   9'h005},
    '{2'd1, K_START,   9'h006},
    '{2'd0, K_COIN,    9'h02E},
    '{2'd1, K_COIN,    9'h036},
    '{2'd2, K_COIN,    9'h03D},
    '{2'd3, K_COIN,    9'h03E},
    '{2'd0, K_TEST,    9'h02C},
    '{2'd0, K_SERVICE, 9'h046}
  };

  function automatic logic [3:0] rotate_dirs(input logic [3:0] p, input rot_e rot);
    logic [3:0] o;
    o = p;
    case (rot)
      ROT_CW: begin
        o[UP]    = p[LEFT];
        o[DOWN]  = p[RIGHT];
        o[LEFT]  = p[DOWN];
        o[RIGHT] = p[UP];
      end
      ROT_CCW: begin
        o[UP]    = p[RIGHT];
        o[DOWN]  = p[LEFT];
        o[LEFT]  = p[UP];
        o[RIGHT] = p[DOWN];
      end
      ROT180: begin
        o[UP]    = p[DOWN];
        o[DOWN]  = p[UP];
        o[LEFT]  = p[RIGHT];
        o[RIGHT] = p[LEFT];
      end
      default: o = p;
    endcase
    return o;
  endfunction

  function automatic logic [3:0] socd_clean(input logic [3:0] d);
    logic [3:0] o;
    o = d;
    if (d[UP] && d[DOWN]) begin
      o[UP]   = 1'b0;
      o[DOWN] = 1'b0;
    end
    if (d[LEFT] && d[RIGHT]) begin
      o[LEFT]  = 1'b0;
      o[RIGHT] = 1'b0;
    end
    return o;
  endfunction

  function automatic int key_btn_index(input key_fn_e fn);
    int idx;
    case (fn)
      K_BTN0:  idx = 0;
      K_BTN1:  idx = 1;
      K_BTN2:  idx = 2;
      default: idx = -1;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/arcade_input_mapper_if.sv
// Bus between hps_io (master) and the arcade input mapper (slave).
//   ps2_key  : [10] toggle per event, [9] pressed, [8] extended, [7:0] scancode
//   joystick : PLAYERS x 16-bit MiSTer joystick words, player 0 in LSBs
//   rotate   : 0 none, 1 cw90, 2 ccw90, 3 flip180
//   dir/btn/start/coin/test/service : active-high registered player controls
//
// Handshake: ps2_key has no valid/ready pair. A new event is present whenever
// bit 10 differs from the value seen on the previous clock; the slave cannot
// stall, so the master must hold each event for at least one clock. All other
// signals are plain levels sampled every clock.
interface arcade_input_mapper_if #(
  parameter int PLAYERS = 2,
  parameter int NBTN    = 3
);
  logic [10:0]             ps2_key;
  logic [PLAYERS*16-1:0]   joystick;
  logic [1:0]              rotate;
  logic [PLAYERS*4-1:0]    dir;
  logic [PLAYERS*NBTN-1:0] btn;
  logic [PLAYERS-1:0]      start;
  logic [PLAYERS-1:0]      coin;
  logic                    test;
  logic                    service;

  modport master (
    output ps2_key, joystick, rotate,
    input  dir, btn, start, coin, test, service
  );

  modport slave (
    input  ps2_key, joystick, rotate,
    output dir, btn, start, coin, test, service
  );
endinterface

// File: rtl/arcade_input_mapper_coin_pulser.sv
// Turns a raw coin level into a fixed-width coin pulse.
//   clk_sys : system clock
//   reset_n : asynchronous active-low reset
//   raw     : coin request level (key or joystick)
//   coin    : registered pulse, high for exactly COIN_CYC cycles per accepted rise
// A rise is accepted only while no pulse is running; rises during a pulse are
// dropped, and a level held past the pulse end never re-fires.
module coin_pulser
  import arcade_input_pkg::*;
#(
  parameter int COIN_CYC = 1000000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic raw,
  output logic coin
);

  localparam int TW = $clog2(COIN_CYC + 1);

  logic [TW-1:0] timer_q;
  logic          raw_q;
  logic          coin_q;

  // timer_q counts the cycles still to go after the current one, so loading
  // COIN_CYC-1 on the trigger edge yields COIN_CYC high cycles in total.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      timer_q <= '0;
      raw_q   <= 1'b0;
      coin_q  <= 1'b0;
    end else begin
      raw_q <= raw;
      if (coin_q) begin
        if (timer_q == '0) begin
          coin_q <= 1'b0;
        end else begin
          timer_q <= timer_q - 1'b1;
        end
      end else if (raw && !raw_q) begin
        coin_q  <= 1'b1;
        timer_q <= TW'(COIN_CYC - 1);
      end
    end
  end

  assign coin = coin_q;

endmodule

// File: rtl/arcade_input_mapper.sv
// Player-input front end between hps_io and an arcade core.
//   clk_sys : system clock
//   reset_n : asynchronous active-low reset
//   io      : arcade_input_mapper_if slave (ps2_key, joystick, rotate in;
//             dir, btn, start, coin, test, service out)
// Keyboard events are decoded into held-key state, merged with registered
// joystick words, rotated, SOCD-cleaned and registered onto the outputs.
// Coin outputs come from one coin_pulser per player.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int PLAYERS       = 2,
  parameter int NBTN          = 3,
  parameter int JOY_SHARE     = 0,
  parameter int SOCD_NEUTRAL  = 1,
  parameter int COIN_CYC      = 1000000,
  parameter int JOY_START_BIT = 10,
  parameter int JOY_COIN_BIT  = 11
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  arcade_input_mapper_if.slave io
);

  // ---------------------------------------------------------------------
  // Keyboard event detect and held-key state
  // ---------------------------------------------------------------------
  logic                old_tog_q;
  logic                primed_q;
  logic                key_event;
  logic [8:0]          ev_code;
  logic                ev_pressed;

  logic [3:0]          key_dir_q [PLAYERS];
  logic [NBTN-1:0]     key_btn_q [PLAYERS];
  logic [PLAYERS-1:0]  key_start_q;
  logic [PLAYERS-1:0]  key_coin_q;
  logic                key_test_q;
  logic                key_service_q;

  // The first edge after reset only learns the toggle level, so whatever
  // level the toggle had at reset release is never mistaken for an event.
  assign key_event  = primed_q && (io.ps2_key[10] != old_tog_q);
  assign ev_code    = io.ps2_key[8:0];
  assign ev_pressed = io.ps2_key[9];

  // Entries for players beyond PLAYERS match no loop index and are dropped,
  // which masks them without special-casing the table.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      old_tog_q     <= 1'b0;
      primed_q      <= 1'b0;
      key_start_q   <= '0;
      key_coin_q    <= '0;
      key_test_q    <= 1'b0;
      key_service_q <= 1'b0;
      for (int p = 0; p < PLAYERS; p++) begin
        key_dir_q[p] <= '0;
        key_btn_q[p] <= '0;
      end
    end else begin
      old_tog_q <= io.ps2_key[10];
      primed_q  <= 1'b1;
      if (key_event) begin
        for (int i = 0; i < NKEYS; i++) begin
          if (KEYMAP[i].code == ev_code) begin
            for (int p = 0; p < PLAYERS; p++) begin
              if (KEYMAP[i].player == 2'(p)) begin
                case (KEYMAP[i].fn)
                  K_UP:      key_dir_q[p][UP]    <= ev_pressed;
                  K_DOWN:    key_dir_q[p][DOWN]  <= ev_pressed;
                  K_LEFT:    key_dir_q[p][LEFT]  <= ev_pressed;
                  K_RIGHT:   key_dir_q[p][RIGHT] <= ev_pressed;
                  K_BTN0, K_BTN1, K_BTN2: begin
                    for (int k = 0; k < NBTN; k++) begin
                      if (key_btn_index(KEYMAP[i].fn) == k) begin
                        key_btn_q[p][k] <= ev_pressed;
                      end
                    end
                  end
                  K_START:   key_start_q[p] <= ev_pressed;
                  K_COIN:    key_coin_q[p]  <= ev_pressed;
                  K_TEST:    key_test_q     <= ev_pressed;
                  K_SERVICE: key_service_q  <= ev_pressed;
                  default:   ;
                endcase
              end
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Joystick registration and source selection
  // ---------------------------------------------------------------------
  logic [JOY_WORD-1:0] jreg_q [PLAYERS];
  logic [JOY_WORD-1:0] jsrc   [PLAYERS];
  logic [JOY_WORD-1:0] joy_or;
  logic [JOY_WORD-1:0] jsrc_fold;
  logic                unused_jsrc_bits;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < PLAYERS; p++) begin
        jreg_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < PLAYERS; p++) begin
        jreg_q[p] <= io.joystick[p*JOY_WORD +: JOY_WORD];
      end
    end
  end

  always_comb begin
    joy_or    = '0;
    jsrc_fold = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      joy_or = joy_or | jreg_q[p];
    end
    for (int p = 0; p < PLAYERS; p++) begin
      jsrc[p]   = (JOY_SHARE != 0) ? joy_or : jreg_q[p];
      jsrc_fold = jsrc_fold ^ jsrc[p];
    end
  end

  // Joystick bits outside the mapped functions are intentionally ignored.
  assign unused_jsrc_bits = ^jsrc_fold;

  // ---------------------------------------------------------------------
  // Merge, rotate, clean
  // ---------------------------------------------------------------------
  logic [3:0]         phys_w  [PLAYERS];
  logic [3:0]         rot_w   [PLAYERS];
  logic [3:0]         dir_nx  [PLAYERS];
  logic [NBTN-1:0]    btn_nx  [PLAYERS];
  logic [PLAYERS-1:0] start_nx;
  logic [PLAYERS-1:0] coin_raw;

  // Key state and joystick share the {up,down,left,right} bit layout, so
  // the physical merge is a plain OR of the low nibble.
  always_comb begin
    start_nx = '0;
    coin_raw = '0;
    for (int p = 0; p < PLAYERS; p++) begin
      phys_w[p]   = key_dir_q[p] | jsrc[p][3:0];
      rot_w[p]    = rotate_dirs(phys_w[p], rot_e'(io.rotate));
      dir_nx[p]   = (SOCD_NEUTRAL != 0) ? socd_clean(rot_w[p]) : rot_w[p];
      btn_nx[p]   = key_btn_q[p] | jsrc[p][JOY_BTN0 +: NBTN];
      start_nx[p] = key_start_q[p] | jsrc[p][JOY_START_BIT];
      coin_raw[p] = key_coin_q[p] | jsrc[p][JOY_COIN_BIT];
    end
  end

  // ---------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------
  logic [PLAYERS*4-1:0]    dir_q;
  logic [PLAYERS*NBTN-1:0] btn_q;
  logic [PLAYERS-1:0]      start_q;
  logic                    test_q;
  logic                    service_q;
  logic [PLAYERS-1:0]      coin_w;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dir_q     <= '0;
      btn_q     <= '0;
      start_q   <= '0;
      test_q    <= 1'b0;
      service_q <= 1'b0;
    end else begin
      for (int p = 0; p < PLAYERS; p++) begin
        dir_q[p*4 +: 4]       <= dir_nx[p];
        btn_q[p*NBTN +: NBTN] <= btn_nx[p];
      end
      start_q   <= start_nx;
      test_q    <= key_test_q;
      service_q <= key_service_q;
    end
  end

  for (genvar gp = 0; gp < PLAYERS; gp++) begin : g_coin
    coin_pulser #(
      .COIN_CYC (COIN_CYC)
    ) u_coin (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .raw     (coin_raw[gp]),
      .coin    (coin_w[gp])
    );
  end

  assign io.dir     = dir_q;
  assign io.btn     = btn_q;
  assign io.start   = start_q;
  assign io.coin    = coin_w;
  assign io.test    = test_q;
  assign io.service = service_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: two instances share all stimulus, one with
// per-player joysticks and one with shared joysticks. A behavioural model
// (held-key table, rotation lookup table, coin pulse countdown) predicts every
// output each cycle; directed scenarios add fixed expectations on top.
module tb_arcade_input_mapper;

  localparam int PLAYERS  = 2;
  localparam int NBTN     = 3;
  localparam int COIN_CYC = 8;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic [10:0] ps2_key;
  logic [31:0] joystick;
  logic [1:0]  rotate;

  arcade_input_mapper_if #(.PLAYERS(PLAYERS), .NBTN(NBTN)) io_a ();
  arcade_input_mapper_if #(.PLAYERS(PLAYERS), .NBTN(NBTN)) io_b ();

  assign io_a.ps2_key  = ps2_key;
  assign io_a.joystick = joystick;
  assign io_a.rotate   = rotate;
  assign io_b.ps2_key  = ps2_key;
  assign io_b.joystick = joystick;
  assign io_b.rotate   = rotate;

  arcade_input_mapper #(
    .PLAYERS(PLAYERS), .NBTN(NBTN), .JOY_SHARE(0), .SOCD_NEUTRAL(1),
    .COIN_CYC(COIN_CYC), .JOY_START_BIT(10), .JOY_COIN_BIT(11)
  ) dut_a (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .io      (io_a)
  );

  arcade_input_mapper #(
    .PLAYERS(PLAYERS), .NBTN(NBTN), .JOY_SHARE(1), .SOCD_NEUTRAL(1),
    .COIN_CYC(COIN_CYC), .JOY_START_BIT(10), .JOY_COIN_BIT(11)
  ) dut_b (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .io      (io_b)
  );

  // ---------------- scoreboard / checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Direction order inside the model: 0=up 1=down 2=left 3=right.
  localparam int DIR_CODE [2][4] = '{'{'h175, 'h172, 'h16B, 'h174},
                                     '{'h02D, 'h02B, 'h023, 'h034}};
  localparam int BTN_CODE [2][3] = '{'{'h014, 'h011, 'h029},
                                     '{'h01C, 'h01B, 'h015}};
  localparam int START_CODE [2] = '{'h016, 'h01E};
  localparam int START_ALT  [2] = '{'h005, 'h006};
  localparam int COIN_CODE  [2] = '{'h02E, 'h036};
  // For each rotate value, which physical direction feeds output u,d,l,r.
  localparam int ROT_SRC [4][4] = '{'{0, 1, 2, 3},
                                    '{2, 3, 1, 0},
                                    '{3, 2, 0, 1},
                                    '{1, 0, 3, 2}};

  bit          held [512];
  bit          m_primed;
  bit          m_old;
  logic [15:0] mj [2];
  int          rem [2][2];
  bit          rawp [2][2];

  logic [7:0] e_dir   [2];
  logic [5:0] e_btn   [2];
  logic [1:0] e_start [2];
  logic [1:0] e_coin  [2];
  logic       e_test;
  logic       e_service;

  function automatic void model_reset();
    for (int c = 0; c < 512; c++) held[c] = 1'b0;
    m_primed = 1'b0;
    m_old    = 1'b0;
    for (int s = 0; s < 2; s++) begin
      mj[s]      = '0;
      e_dir[s]   = '0;
      e_btn[s]   = '0;
      e_start[s] = '0;
      e_coin[s]  = '0;
      for (int p = 0; p < 2; p++) begin
        rem[s][p]  = 0;
        rawp[s][p] = 1'b0;
      end
    end
    e_test    = 1'b0;
    e_service = 1'b0;
  endfunction

  // s=0: instance with own joysticks, s=1: instance with shared joysticks.
  function automatic void model_eval();
    logic [15:0] w;
    bit ph [4];
    bit r  [4];
    bit raw;
    for (int s = 0; s < 2; s++) begin
      for (int p = 0; p < 2; p++) begin
        w = (s == 1) ? (mj[0] | mj[1]) : mj[p];
        for (int d = 0; d < 4; d++) ph[d] = held[DIR_CODE[p][d]] | w[3-d];
        for (int o = 0; o < 4; o++) r[o] = ph[ROT_SRC[rotate][o]];
        if (r[0] && r[1]) begin r[0] = 1'b0; r[1] = 1'b0; end
        if (r[2] && r[3]) begin r[2] = 1'b0; r[3] = 1'b0; end
        e_dir[s][p*4 +: 4] = {r[0], r[1], r[2], r[3]};
        for (int k = 0; k < 3; k++) e_btn[s][p*3+k] = held[BTN_CODE[p][k]] | w[4+k];
        e_start[s][p] = held[START_CODE[p]] | held[START_ALT[p]] | w[10];
        raw = held[COIN_CODE[p]] | w[11];
        if (rem[s][p] > 0) rem[s][p]--;
        else if (raw && !rawp[s][p]) rem[s][p] = COIN_CYC;
        rawp[s][p]    = raw;
        e_coin[s][p]  = (rem[s][p] > 0);
      end
    end
    e_test    = held['h02C];
    e_service = held['h046];
  endfunction

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      model_reset();
    end else begin
      model_eval();
      if (!m_primed) m_primed = 1'b1;
      else if (ps2_key[10] != m_old) held[ps2_key[8:0]] = ps2_key[9];
      m_old = ps2_key[10];
      mj[0] = joystick[15:0];
      mj[1] = joystick[31:16];
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk_sys) begin
    if (chk_en) begin
      check_eq("a_dir",     io_a.dir,     e_dir[0]);
      check_eq("a_btn",     io_a.btn,     e_btn[0]);
      check_eq("a_start",   io_a.start,   e_start[0]);
      check_eq("a_coin",    io_a.coin,    e_coin[0]);
      check_eq("b_dir",     io_b.dir,     e_dir[1]);
      check_eq("b_btn",     io_b.btn,     e_btn[1]);
      check_eq("b_start",   io_b.start,   e_start[1]);
      check_eq("b_coin",    io_b.coin,    e_coin[1]);
      check_eq("test",      io_a.test,    e_test);
      check_eq("service",   io_b.service, e_service);
    end
  end

  // Coin[0] activity of instance a, counted every cycle.
  int   coin_hi   = 0;
  int   coin_rise = 0;
  logic coin_prev = 1'b0;
  always @(negedge clk_sys) begin
    if (io_a.coin[0]) coin_hi++;
    if (io_a.coin[0] && !coin_prev) coin_rise++;
    coin_prev = io_a.coin[0];
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_key(input bit pressed, input int code);
    ps2_key = {~ps2_key[10], pressed, code[8:0]};
  endtask

  localparam int NRND = 20;
  localparam int RND_CODES [NRND] = '{'h175, 'h172, 'h16B, 'h174, 'h014, 'h029,
                                      'h02D, 'h023, 'h034, 'h01B, 'h016, 'h006,
                                      'h026, 'h02E, 'h036, 'h03D, 'h02C, 'h046,
                                      'h01A, 'h075};

  // ---------------- main sequence ----------------
  int nz;
  int h0, r0;

  initial begin
    ps2_key  = 11'h400;
    joystick = '0;
    rotate   = 2'd0;
    reset_n  = 1'b0;
    tick(3);
    check_eq("reset_dir",  io_a.dir,  0);
    check_eq("reset_coin", io_a.coin, 0);
    check_eq("reset_btn",  io_b.btn,  0);
    chk_en  = 1'b1;
    reset_n = 1'b1;

    // Toggle level high at release is not an event.
    nz = 0;
    repeat (100) begin
      @(negedge clk_sys);
      if ((io_a.dir | io_a.btn | io_a.start | io_a.coin) != 0 || io_a.test || io_a.service) nz++;
    end
    check_eq("idle_nonzero_cycles", nz, 0);

    // Key latency: two edges each way.
    send_key(1'b1, 'h175);
    tick(1); check_eq("up_press_edge1", io_a.dir[3], 1'b0);
    tick(1); check_eq("up_press_edge2", io_a.dir[3], 1'b1);
    send_key(1'b0, 'h175);
    tick(1); check_eq("up_rel_edge1", io_a.dir[3], 1'b1);
    tick(1); check_eq("up_rel_edge2", io_a.dir[3], 1'b0);

    // Rotation.
    rotate   = 2'd1;
    joystick = 32'h0000_0002;
    tick(3);
    check_eq("rot_cw_up",   io_a.dir[3], 1'b1);
    check_eq("rot_cw_left", io_a.dir[1], 1'b0);
    rotate = 2'd3;
    tick(1);
    check_eq("rot180_right", io_a.dir[0], 1'b1);

    // SOCD cleaning.
    rotate   = 2'd0;
    joystick = 32'h0000_000C;
    tick(3);
    check_eq("socd_ud", io_a.dir[3:2], 2'b00);
    joystick = 32'h0000_000E;
    tick(3);
    check_eq("socd_ud_left", io_a.dir[3:0], 4'b0010);
    joystick = '0;
    tick(3);

    // Coin: one pulse for a long hold.
    h0 = coin_hi; r0 = coin_rise;
    send_key(1'b1, 'h02E);
    tick(20);
    send_key(1'b0, 'h02E);
    tick(4);
    check_eq("coin_hold_width", coin_hi - h0, COIN_CYC);
    check_eq("coin_hold_pulses", coin_rise - r0, 1);

    // Coin: re-press during pulse does not extend it.
    h0 = coin_hi; r0 = coin_rise;
    send_key(1'b1, 'h02E);
    tick(4);
    send_key(1'b0, 'h02E);
    tick(1);
    send_key(1'b1, 'h02E);
    tick(14);
    send_key(1'b0, 'h02E);
    tick(4);
    check_eq("coin_repress_width", coin_hi - h0, COIN_CYC);
    check_eq("coin_repress_pulses", coin_rise - r0, 1);

    // Coin: release then press gives a fresh pulse.
    h0 = coin_hi; r0 = coin_rise;
    send_key(1'b1, 'h02E);
    tick(14);
    send_key(1'b0, 'h02E);
    tick(4);
    check_eq("coin_second_width", coin_hi - h0, COIN_CYC);
    check_eq("coin_second_pulses", coin_rise - r0, 1);

    // Joystick sharing.
    joystick = 32'h0010_0000;
    tick(3);
    check_eq("share_b_btn0", io_b.btn[0], 1'b1);
    check_eq("share_b_btn3", io_b.btn[3], 1'b1);
    check_eq("own_a_btn0",   io_a.btn[0], 1'b0);
    check_eq("own_a_btn3",   io_a.btn[3], 1'b1);
    joystick = '0;
    tick(3);

    // Reset in the middle of a coin pulse.
    joystick = 32'h0800_0000;
    tick(4);
    check_eq("coin_p2_active", io_a.coin[1], 1'b1);
    @(posedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    check_eq("coin_async_drop_a", io_a.coin, 0);
    check_eq("coin_async_drop_b", io_b.coin, 0);
    tick(2);
    reset_n = 1'b1;
    tick(3);
    check_eq("coin_after_reset", io_a.coin[1], 1'b1);
    joystick = '0;
    tick(12);

    // Randomised traffic against the model.
    repeat (1500) begin
      @(negedge clk_sys);
      if ($urandom_range(0, 3) == 0)
        send_key(1'($urandom_range(0, 1)), RND_CODES[$urandom_range(0, NRND-1)]);
      if ($urandom_range(0, 7) == 0)
        joystick = $urandom & $urandom & 32'h0FFF_0FFF;
      if ($urandom_range(0, 15) == 0)
        rotate = 2'($urandom_range(0, 3));
    end
    tick(5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
